// File: rtl/dest_forward_unit.sv
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Tracks the destination registers of the instructions in MEM and WB.
module dest_forward_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ex_wreg_i,
    input  logic        ex_regwrite_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rs_i,
    input  logic [4:0]  ex_rt_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        flush_i,
    output logic [1:0]  forward_a_o,
    output logic [1:0]  forward_b_o,
    output logic        stall_o,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        idex_bubble_o,
    output logic [4:0]  mem_wreg_o,
    output logic [4:0]  wb_wreg_o,
    output logic [15:0] stall_count_o
);

    logic [4:0]  mem_wreg_q, mem_wreg_d;
    logic        mem_regwrite_q, mem_regwrite_d;
    logic        mem_memread_q, mem_memread_d;
    logic [4:0]  wb_wreg_q, wb_wreg_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic load_use;

    always_comb begin
        mem_hit_a = mem_regwrite_q && (mem_wreg_q != 5'd0) && (mem_wreg_q == ex_rs_i);
        mem_hit_b = mem_regwrite_q && (mem_wreg_q != 5'd0) && (mem_wreg_q == ex_rt_i);
        wb_hit_a  = wb_regwrite_q && (wb_wreg_q != 5'd0) && (wb_wreg_q == ex_rs_i);
        wb_hit_b  = wb_regwrite_q && (wb_wreg_q != 5'd0) && (wb_wreg_q == ex_rt_i);

        // MEM holds the younger result, so it wins over WB.
        forward_a_o = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
        forward_b_o = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);
    end

    always_comb begin
        load_use = ex_memread_i && ex_regwrite_i && (ex_wreg_i != 5'd0) &&
                   ((ex_wreg_i == id_rs_i) || (id_uses_rt_i && (ex_wreg_i == id_rt_i)));
        // A flush squashes the load, so there is nothing to wait for.
        stall_o       = load_use && !flush_i;
        pc_write_o    = !stall_o;
        ifid_write_o  = !stall_o;
        idex_bubble_o = stall_o || flush_i;
        mem_wreg_o    = mem_wreg_q;
        wb_wreg_o     = wb_wreg_q;
        stall_count_o = stall_count_q;
    end

    always_comb begin
        mem_wreg_d     = ex_wreg_i;
        mem_regwrite_d = ex_regwrite_i && !flush_i;
        mem_memread_d  = ex_memread_i && !flush_i;
        wb_wreg_d      = mem_wreg_q;
        wb_regwrite_d  = mem_regwrite_q;
        stall_count_d  = stall_count_q;
        if (stall_o && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_wreg_q     <= 5'd0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            wb_wreg_q      <= 5'd0;
            wb_regwrite_q  <= 1'b0;
            stall_count_q  <= 16'd0;
        end else begin
            mem_wreg_q     <= mem_wreg_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            wb_wreg_q      <= wb_wreg_d;
            wb_regwrite_q  <= wb_regwrite_d;
            stall_count_q  <= stall_count_d;
        end
    end

    // Loads already in MEM can no longer cause a stall; the flag is only carried along.
    logic unused_mem_memread;
    assign unused_mem_memread = mem_memread_q;

endmodule

// File: tb/tb_dest_forward_unit.sv
// Scoreboard bench for dest_forward_unit: a queue-based history model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_dest_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ex_wreg = '0, ex_rs = '0, ex_rt = '0, id_rs = '0, id_rt = '0;
    logic        ex_regwrite = 1'b0, ex_memread = 1'b0, id_uses_rt = 1'b0, flush = 1'b0;
    logic [1:0]  forward_a, forward_b;
    logic        stall, pc_write, ifid_write, idex_bubble;
    logic [4:0]  mem_wreg, wb_wreg;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    dest_forward_unit u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ex_wreg_i     (ex_wreg),
        .ex_regwrite_i (ex_regwrite),
        .ex_memread_i  (ex_memread),
        .ex_rs_i       (ex_rs),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .flush_i       (flush),
        .forward_a_o   (forward_a),
        .forward_b_o   (forward_b),
        .stall_o       (stall),
        .pc_write_o    (pc_write),
        .ifid_write_o  (ifid_write),
        .idex_bubble_o (idex_bubble),
        .mem_wreg_o    (mem_wreg),
        .wb_wreg_o     (wb_wreg),
        .stall_count_o (stall_count)
    );

    typedef struct {
        logic [4:0] wreg;
        bit         writes;
    } instr_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        stall, pcw, ifidw, bubble;
        logic [4:0]  mem_wreg, wb_wreg;
        logic [15:0] cnt;
    } exp_t;

    instr_t retired[$];   // retired[$] is the instruction in MEM, retired[$-1] in WB
    int     model_cnt;
    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Youngest older writer of r, looking back at most two instructions.
    function automatic logic [1:0] model_fwd(logic [4:0] r);
        int n = retired.size();
        if (r == 5'd0) return 2'b00;
        for (int age = 0; age < 2 && age < n; age++) begin
            if (retired[n-1-age].writes && retired[n-1-age].wreg == r)
                return (age == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        bit hazard;
        hazard = ex_memread && ex_regwrite && ex_wreg != 5'd0 &&
                 (ex_wreg == id_rs || (id_uses_rt && ex_wreg == id_rt));
        return hazard && !flush;
    endfunction

    task automatic model_edge();
        instr_t in;
        if (!rst_n) begin
            retired.delete();
            model_cnt = 0;
        end else begin
            if (model_stall()) model_cnt = (model_cnt >= 65535) ? 65535 : model_cnt + 1;
            in.wreg   = ex_wreg;
            in.writes = ex_regwrite && !flush;
            retired.push_back(in);
            if (retired.size() > 2) void'(retired.pop_front());
        end
    endtask

    task automatic step(input bit r, input int w, input bit rw, input bit mr, input int rs,
                        input int rt, input int irs, input int irt, input bit ut, input bit fl);
        exp_t e;
        int   n;
        @(posedge clk);
        model_edge();
        #1;
        rst_n = r; ex_wreg = 5'(w); ex_regwrite = rw; ex_memread = mr;
        ex_rs = 5'(rs); ex_rt = 5'(rt); id_rs = 5'(irs); id_rt = 5'(irt);
        id_uses_rt = ut; flush = fl;
        n = retired.size();
        e.fa       = model_fwd(ex_rs);
        e.fb       = model_fwd(ex_rt);
        e.stall    = model_stall();
        e.pcw      = !e.stall;
        e.ifidw    = !e.stall;
        e.bubble   = e.stall || fl;
        e.mem_wreg = (n >= 1) ? retired[n-1].wreg : 5'd0;
        e.wb_wreg  = (n >= 2) ? retired[n-2].wreg : 5'd0;
        e.cnt      = 16'(model_cnt);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("forward_a", int'(forward_a), int'(e.fa));
            check("forward_b", int'(forward_b), int'(e.fb));
            check("stall", int'(stall), int'(e.stall));
            check("pc_write", int'(pc_write), int'(e.pcw));
            check("ifid_write", int'(ifid_write), int'(e.ifidw));
            check("idex_bubble", int'(idex_bubble), int'(e.bubble));
            check("mem_wreg", int'(mem_wreg), int'(e.mem_wreg));
            check("wb_wreg", int'(wb_wreg), int'(e.wb_wreg));
            check("stall_count", int'(stall_count), int'(e.cnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_cnt = 0;
        //    rst w  rw mr rs rt irs irt ut fl
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add $3, then consumers in rs (MEM) and rt (WB)
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        // two writers of $5 back to back, consumer sees MEM
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 5, 0, 0, 0, 0);
        // lw $4 with dependent in ID: one stall, bubble, then WB forward
        step(1, 4, 1, 1, 0, 0, 4, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        step(1, 2, 1, 0, 4, 0, 0, 0, 0, 0);
        // rt hazard only counts when ID uses rt
        step(1, 6, 1, 1, 0, 0, 1, 6, 0, 0);
        step(1, 6, 1, 1, 0, 0, 1, 6, 1, 0);
        // register zero never forwards or stalls
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // flush with load-use pending, then consumer of flushed wreg
        step(1, 7, 1, 1, 0, 0, 7, 0, 0, 1);
        step(1, 0, 0, 0, 7, 7, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 7, 0, 0, 0, 0);
        // reset mid-stall drops tracked state
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 8, 1, 1, 0, 0, 8, 0, 0, 0);
        step(0, 8, 1, 1, 0, 0, 8, 0, 0, 0);
        step(1, 0, 0, 0, 8, 9, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 7), $urandom_range(0, 1),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0));
        end

        // saturate the stall counter, then reset it
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(1, 4, 1, 1, 0, 0, 4, 0, 0, 0);
        step(1, 4, 1, 1, 4, 4, 4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 4, 4, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dest_forward_unit.md
DEST_FORWARD_UNIT -- requirements
Module: dest_forward_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset; sampled only on the rising edge of clk.
REQ-004 ex_wreg  input  5  destination register of the instruction in EX, as selected by RegDst (rd or rt).
REQ-005 ex_regwrite  input  1  instruction in EX writes the register file.
REQ-006 ex_memread  input  1  instruction in EX is a load.
REQ-007 ex_rs, ex_rt  input  5 each  source registers of the instruction in EX.
REQ-008 id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-009 id_uses_rt  input  1  ID instruction reads rt as a source (R-type, beq, sw).
REQ-010 flush  input  1  squash the instruction in EX (taken branch or jump).
REQ-011 forward_a, forward_b  output  2 each  ALU operand select: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
REQ-012 stall  output  1  load-use hazard detected this cycle.
REQ-013 pc_write, ifid_write  output  1 each  equal to ~stall.
REQ-014 idex_bubble  output  1  equal to stall or flush; zeroes the ID/EX control bits.
REQ-015 mem_wreg, wb_wreg  output  5 each  tracked destination registers in MEM and WB.
REQ-016 stall_count  output  16  number of stall cycles since reset; saturating.

Function
REQ-017 Each rising edge SHALL load {ex_wreg, ex_regwrite, ex_memread} into the MEM tracking register and the previous MEM contents into the WB tracking register.
REQ-018 When flush=1, the MEM tracking register SHALL load regwrite=0 and memread=0; wreg SHALL be loaded but ignored.
REQ-019 The MEM stage SHALL match operand A when mem_regwrite=1, mem_wreg != 0, and mem_wreg == ex_rs; operand B is identical with ex_rt.
REQ-020 The WB stage SHALL match operand A when wb_regwrite=1, wb_wreg != 0, and wb_wreg == ex_rs; operand B is identical with ex_rt.
REQ-021 forward_a SHALL be 10 on a MEM match; otherwise 01 on a WB match; otherwise 00. forward_b follows the same rule.
REQ-022 MEM SHALL take priority over WB when both match.
REQ-023 forward_a/b SHALL be combinational from the current tracking state and ex_rs/ex_rt (zero-cycle latency).
REQ-024 Register 0 SHALL never be forwarded or cause a stall.
REQ-025 stall SHALL be 1 combinationally when all of the following hold: ex_memread=1; ex_regwrite=1; ex_wreg != 0; and either ex_wreg == id_rs, or (id_uses_rt=1 and ex_wreg == id_rt).
REQ-026 A stall SHALL last exactly one cycle per load-use pair; the bubble enters MEM on the next edge, and that bubble has regwrite=0.
REQ-027 When stall and flush are both asserted, flush SHALL win: stall SHALL be forced to 0, and idex_bubble SHALL be 1.
REQ-028 stall_count SHALL increment by 1 on every edge where stall=1, and SHALL hold at 16'hFFFF once reached (no wrap-around).

Reset
REQ-029 While rst_n=0 at an edge, the MEM and WB tracking registers SHALL clear to wreg=0, regwrite=0, memread=0.
REQ-030 While rst_n=0 at an edge, stall_count SHALL clear to 0.
REQ-031 After reset, forward_a and forward_b SHALL be 00, and stall SHALL be 0 until a hazard appears at the inputs.
REQ-032 Reset asserted mid-stall SHALL discard all tracked state, with no forwarding from pre-reset instructions.
REQ-033 rst_n SHALL have priority over flush and stall.

Verification
REQ-034 add $3 (ex_wreg=3, regwrite=1), then next cycle ex_rs=3 -> forward_a=10; one cycle later ex_rt=3 -> forward_b=01.
REQ-035 $5 written by two consecutive instructions, with the consumer ex_rs=5 -> forward_a=10 (MEM priority).
REQ-036 lw with ex_wreg=4, ex_memread=1, and id_rs=4 -> stall=1, pc_write=0, idex_bubble=1 for exactly one cycle; the next cycle gives forward_a=01.
REQ-037 ex_wreg=0 with regwrite=1, and ex_rs=0 next cycle -> forward_a=00; lw with ex_wreg=0 and id_rs=0 -> stall=0.
REQ-038 flush=1 on the same cycle as a load-use condition -> stall=0, idex_bubble=1; and a consumer matching the flushed wreg the next cycle -> forward=00.
REQ-039 Hold the stall condition for 70000 cycles -> stall_count=16'hFFFF and it stays there; then rst_n=0 for one edge -> stall_count=0 and all tracking cleared.
